// File: rtl/mac_table_scheduler_if.sv
// Request/grant and datapath-control bundle for the MAC table scheduler.
// The scheduler connects through the slave modport; the requesters/datapath use master.
interface mac_table_scheduler_if #(
    parameter int pMAX_PORT_NUMBER = 16,
    parameter int pADRESS          = 4,
    parameter int pTABLE_AW        = 10
);
    logic [pMAX_PORT_NUMBER-1:0] i_lkp_req;
    logic [pMAX_PORT_NUMBER-1:0] i_learn_req;
    logic                        i_op_done;
    logic                        o_op_start;
    logic [1:0]                  o_op_type;
    logic [pADRESS-1:0]          o_op_port;
    logic [pTABLE_AW-1:0]        o_age_addr;
    logic [pMAX_PORT_NUMBER-1:0] o_lkp_gnt;
    logic [pMAX_PORT_NUMBER-1:0] o_learn_gnt;
    logic                        o_busy;
    logic                        o_age_overrun;

    modport master (
        output i_lkp_req, i_learn_req, i_op_done,
        input  o_op_start, o_op_type, o_op_port, o_age_addr,
               o_lkp_gnt, o_learn_gnt, o_busy, o_age_overrun
    );

    modport slave (
        input  i_lkp_req, i_learn_req, i_op_done,
        output o_op_start, o_op_type, o_op_port, o_age_addr,
               o_lkp_gnt, o_learn_gnt, o_busy, o_age_overrun
    );
endinterface

// File: rtl/mac_table_scheduler.sv
// Single-owner sequencer for the MAC table datapath: round-robin lookups and learns,
// periodic aging sweep, lookup-burst cap and learn/age alternation.
module mac_table_scheduler #(
    parameter int pMAX_PORT_NUMBER = 16,
    parameter int pADRESS          = 4,
    parameter int pTABLE_AW        = 10,
    parameter int pAGE_PERIOD      = 1000000,
    parameter int pLKP_BURST       = 4
) (
    input  logic                 iclk,
    input  logic                 irst_n,
    mac_table_scheduler_if.slave io_bus
);
    localparam int unsigned STREAK_W = $clog2(pLKP_BURST + 1);
    localparam int unsigned TIMER_W  = $clog2(pAGE_PERIOD);
    localparam int unsigned PW       = pADRESS + 1;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(pLKP_BURST);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(pAGE_PERIOD - 1);
    localparam logic [PW-1:0]       PORT_CNT   = PW'(pMAX_PORT_NUMBER);
    localparam logic [pADRESS-1:0]  LAST_PORT  = pADRESS'(pMAX_PORT_NUMBER - 1);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;
    typedef enum logic [1:0] {OP_NONE = 2'b00, OP_LKP = 2'b01, OP_LRN = 2'b10, OP_AGE = 2'b11} op_t;

    // Returns {found, port}: first requesting port at or after ptr, wrapping.
    function automatic logic [PW-1:0] f_rr_pick(
        input logic [pMAX_PORT_NUMBER-1:0] req,
        input logic [pADRESS-1:0]          ptr
    );
        logic [PW-1:0] res;
        logic [PW-1:0] idx;
        res = '0;
        for (int unsigned i = 0; i < pMAX_PORT_NUMBER; i++) begin
            idx = {1'b0, ptr} + PW'(i);
            if (idx >= PORT_CNT) idx = idx - PORT_CNT;
            if (!res[pADRESS] && req[idx[pADRESS-1:0]]) res = {1'b1, idx[pADRESS-1:0]};
        end
        return res;
    endfunction

    function automatic logic [pADRESS-1:0] f_ptr_next(input logic [pADRESS-1:0] port);
        return (port == LAST_PORT) ? '0 : port + 1'b1;
    endfunction

    state_t                      r_state, w_state_nxt;
    op_t                         r_op_type, w_op_type_nxt;
    logic                        r_op_start, w_op_start_nxt;
    logic [pADRESS-1:0]          r_op_port, w_op_port_nxt;
    logic [pMAX_PORT_NUMBER-1:0] r_lkp_gnt, w_lkp_gnt_nxt;
    logic [pMAX_PORT_NUMBER-1:0] r_learn_gnt, w_learn_gnt_nxt;
    logic                        r_busy, w_busy_nxt;
    logic [pADRESS-1:0]          r_lkp_ptr, r_lrn_ptr;
    logic [STREAK_W-1:0]         r_streak;
    logic [TIMER_W-1:0]          r_age_timer;
    logic                        r_sweep_active, r_toggle, r_age_overrun;
    logic [pTABLE_AW-1:0]        r_age_addr;

    logic [PW-1:0] w_lkp_pick, w_lrn_pick;
    logic          w_lkp_pend, w_lrn_pend, w_age_pend, w_other_pend, w_cap_hit;
    logic          w_grant_lkp, w_grant_lrn, w_grant_age;
    logic          w_timer_wrap, w_age_done;

    assign w_lkp_pick   = f_rr_pick(io_bus.i_lkp_req, r_lkp_ptr);
    assign w_lrn_pick   = f_rr_pick(io_bus.i_learn_req, r_lrn_ptr);
    assign w_lkp_pend   = w_lkp_pick[pADRESS];
    assign w_lrn_pend   = w_lrn_pick[pADRESS];
    assign w_age_pend   = r_sweep_active && (r_state != ST_BUSY);
    assign w_other_pend = w_lrn_pend || w_age_pend;
    assign w_cap_hit    = (r_streak == STREAK_MAX) && w_other_pend;
    assign w_timer_wrap = (r_age_timer == TIMER_LAST);
    assign w_age_done   = (r_state == ST_BUSY) && io_bus.i_op_done && (r_op_type == OP_AGE);

    always_comb begin
        w_state_nxt     = r_state;
        w_op_start_nxt  = 1'b0;
        w_op_type_nxt   = r_op_type;
        w_op_port_nxt   = r_op_port;
        w_lkp_gnt_nxt   = '0;
        w_learn_gnt_nxt = '0;
        w_busy_nxt      = r_busy;
        w_grant_lkp     = 1'b0;
        w_grant_lrn     = 1'b0;
        w_grant_age     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_lkp_pend && !w_cap_hit) begin
                    w_grant_lkp = 1'b1;
                end else if (w_lrn_pend && w_age_pend) begin
                    w_grant_lrn = !r_toggle;
                    w_grant_age = r_toggle;
                end else begin
                    w_grant_lrn = w_lrn_pend;
                    w_grant_age = w_age_pend;
                end

                if (w_grant_lkp) begin
                    w_op_type_nxt = OP_LKP;
                    w_op_port_nxt = w_lkp_pick[pADRESS-1:0];
                    w_lkp_gnt_nxt[w_lkp_pick[pADRESS-1:0]] = 1'b1;
                end else if (w_grant_lrn) begin
                    w_op_type_nxt = OP_LRN;
                    w_op_port_nxt = w_lrn_pick[pADRESS-1:0];
                    w_learn_gnt_nxt[w_lrn_pick[pADRESS-1:0]] = 1'b1;
                end else if (w_grant_age) begin
                    w_op_type_nxt = OP_AGE;
                    w_op_port_nxt = '0;
                end

                if (w_grant_lkp || w_grant_lrn || w_grant_age) begin
                    w_state_nxt    = ST_BUSY;
                    w_op_start_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                end
            end
            ST_BUSY: begin
                if (io_bus.i_op_done) begin
                    w_state_nxt   = ST_IDLE;
                    w_busy_nxt    = 1'b0;
                    w_op_type_nxt = OP_NONE;
                    w_op_port_nxt = '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_op_start     <= 1'b0;
            r_op_type      <= OP_NONE;
            r_op_port      <= '0;
            r_lkp_gnt      <= '0;
            r_learn_gnt    <= '0;
            r_busy         <= 1'b0;
            r_lkp_ptr      <= '0;
            r_lrn_ptr      <= '0;
            r_streak       <= '0;
            r_toggle       <= 1'b0;
            r_age_timer    <= '0;
            r_sweep_active <= 1'b0;
            r_age_addr     <= '0;
            r_age_overrun  <= 1'b0;
        end else begin
            r_op_start  <= w_op_start_nxt;
            r_op_type   <= w_op_type_nxt;
            r_op_port   <= w_op_port_nxt;
            r_lkp_gnt   <= w_lkp_gnt_nxt;
            r_learn_gnt <= w_learn_gnt_nxt;
            r_busy      <= w_busy_nxt;

            if (w_grant_lkp) r_lkp_ptr <= f_ptr_next(w_lkp_pick[pADRESS-1:0]);
            if (w_grant_lrn) r_lrn_ptr <= f_ptr_next(w_lrn_pick[pADRESS-1:0]);
            if (w_grant_lrn || w_grant_age) r_toggle <= ~r_toggle;

            // Streak is only judged in selection cycles; an age op is never pending while BUSY.
            if (r_state == ST_IDLE) begin
                if (w_grant_lrn || w_grant_age || !w_other_pend) r_streak <= '0;
                else if (w_grant_lkp && (r_streak != STREAK_MAX)) r_streak <= r_streak + 1'b1;
            end

            r_age_timer   <= w_timer_wrap ? '0 : r_age_timer + 1'b1;
            r_age_overrun <= w_timer_wrap && r_sweep_active;
            if (w_timer_wrap && !r_sweep_active) begin
                r_sweep_active <= 1'b1;
                r_age_addr     <= '0;
            end
            if (w_age_done) begin
                r_age_addr <= r_age_addr + 1'b1;
                if (&r_age_addr) r_sweep_active <= 1'b0;
            end
        end
    end

    assign io_bus.o_op_start    = r_op_start;
    assign io_bus.o_op_type     = r_op_type;
    assign io_bus.o_op_port     = r_op_port;
    assign io_bus.o_age_addr    = r_age_addr;
    assign io_bus.o_lkp_gnt     = r_lkp_gnt;
    assign io_bus.o_learn_gnt   = r_learn_gnt;
    assign io_bus.o_busy        = r_busy;
    assign io_bus.o_age_overrun = r_age_overrun;
endmodule

// File: tb/tb_mac_table_scheduler.sv
// Directed bench: main instance for lookup/learn arbitration and reset, two small-table
// instances for the aging sweep, learn/age alternation and sweep overrun.
module tb_mac_table_scheduler;
    logic clk = 1'b0;
    logic rst_m = 1'b0;
    logic rst_a = 1'b0;
    logic rst_o = 1'b0;

    always #5 clk = ~clk;

    mac_table_scheduler_if #(.pMAX_PORT_NUMBER(16), .pADRESS(4), .pTABLE_AW(10)) m_if ();
    mac_table_scheduler_if #(.pMAX_PORT_NUMBER(16), .pADRESS(4), .pTABLE_AW(2))  a_if ();
    mac_table_scheduler_if #(.pMAX_PORT_NUMBER(16), .pADRESS(4), .pTABLE_AW(2))  o_if ();

    mac_table_scheduler #(
        .pMAX_PORT_NUMBER(16), .pADRESS(4), .pTABLE_AW(10), .pAGE_PERIOD(1000000), .pLKP_BURST(4)
    ) u_main (.iclk(clk), .irst_n(rst_m), .io_bus(m_if));

    mac_table_scheduler #(
        .pMAX_PORT_NUMBER(16), .pADRESS(4), .pTABLE_AW(2), .pAGE_PERIOD(50), .pLKP_BURST(4)
    ) u_age (.iclk(clk), .irst_n(rst_a), .io_bus(a_if));

    mac_table_scheduler #(
        .pMAX_PORT_NUMBER(16), .pADRESS(4), .pTABLE_AW(2), .pAGE_PERIOD(20), .pLKP_BURST(4)
    ) u_ovr (.iclk(clk), .irst_n(rst_o), .io_bus(o_if));

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    int unsigned ovr_cnt  = 0;
    int unsigned ovr_wide = 0;
    logic        ovr_prev = 1'b0;

    // Burst-cap expectations: lookup pointer starts at 3, learn request on port 5 held.
    logic [1:0]  b_type [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    int unsigned b_port [10] = '{3, 4, 5, 6, 5, 7, 8, 9, 10, 5};
    logic [1:0]  alt_seq [8] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b10};

    always @(negedge clk) begin
        if (o_if.o_age_overrun === 1'b1) begin
            ovr_cnt++;
            if (ovr_prev === 1'b1) ovr_wide++;
        end
        ovr_prev = o_if.o_age_overrun;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_wait_start(input string tag, input int unsigned bound);
        int unsigned n;
        n = 0;
        while (m_if.o_op_start !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        chk({tag, "_start"}, 32'(m_if.o_op_start), 1);
    endtask

    task automatic m_expect(input string tag, input logic [1:0] typ, input int unsigned port,
                            input logic [15:0] lgnt, input logic [15:0] rgnt);
        chk({tag, "_type"}, 32'(m_if.o_op_type), 32'(typ));
        chk({tag, "_port"}, 32'(m_if.o_op_port), port);
        chk({tag, "_lkp_gnt"}, 32'(m_if.o_lkp_gnt), 32'(lgnt));
        chk({tag, "_learn_gnt"}, 32'(m_if.o_learn_gnt), 32'(rgnt));
    endtask

    task automatic m_done(input string tag);
        step();
        chk({tag, "_busy_hold"}, 32'(m_if.o_busy), 1);
        m_if.i_op_done = 1'b1;
        step();
        m_if.i_op_done = 1'b0;
        chk({tag, "_busy_drop"}, 32'(m_if.o_busy), 0);
    endtask

    task automatic a_wait_start(input string tag, input int unsigned bound);
        int unsigned n;
        n = 0;
        while (a_if.o_op_start !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        chk({tag, "_start"}, 32'(a_if.o_op_start), 1);
    endtask

    task automatic a_done();
        step();
        a_if.i_op_done = 1'b1;
        step();
        a_if.i_op_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned quiet;
        int unsigned n;
        int unsigned exp_addr;
        int unsigned ovr_base;
        logic        seen;

        m_if.i_lkp_req = '0; m_if.i_learn_req = '0; m_if.i_op_done = 1'b0;
        a_if.i_lkp_req = '0; a_if.i_learn_req = '0; a_if.i_op_done = 1'b0;
        o_if.i_lkp_req = '0; o_if.i_learn_req = '0; o_if.i_op_done = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_start", 32'(m_if.o_op_start), 0);
        chk("rst_type", 32'(m_if.o_op_type), 0);
        chk("rst_busy", 32'(m_if.o_busy), 0);
        chk("rst_age_addr", 32'(m_if.o_age_addr), 0);
        chk("rst_gnts", 32'({m_if.o_lkp_gnt, m_if.o_learn_gnt}), 0);
        chk("rst_overrun", 32'(m_if.o_age_overrun), 0);
        rst_m = 1'b1;
        step();
        chk("idle_no_req", 32'(m_if.o_busy), 0);

        // Single lookup request, done three cycles after start
        m_if.i_lkp_req = 16'h0004;
        step();
        chk("single_start", 32'(m_if.o_op_start), 1);
        m_expect("single", 2'b01, 2, 16'h0004, 16'h0000);
        chk("single_busy", 32'(m_if.o_busy), 1);
        m_if.i_lkp_req = '0;
        step();
        chk("single_start_pulse", 32'(m_if.o_op_start), 0);
        chk("single_gnt_pulse", 32'(m_if.o_lkp_gnt), 0);
        chk("single_type_hold", 32'(m_if.o_op_type), 1);
        chk("single_port_hold", 32'(m_if.o_op_port), 2);
        step();
        chk("single_busy_mid", 32'(m_if.o_busy), 1);
        m_if.i_op_done = 1'b1;
        step();
        m_if.i_op_done = 1'b0;
        chk("single_busy_drop", 32'(m_if.o_busy), 0);
        chk("single_type_clear", 32'(m_if.o_op_type), 0);

        // Done while idle is ignored
        m_if.i_op_done = 1'b1;
        step();
        m_if.i_op_done = 1'b0;
        chk("idle_done_busy", 32'(m_if.o_busy), 0);
        chk("idle_done_start", 32'(m_if.o_op_start), 0);

        // Learn round-robin with ports 0 and 15 held
        m_if.i_learn_req = 16'h8001;
        step();
        chk("rr0_start", 32'(m_if.o_op_start), 1);
        m_expect("rr0", 2'b10, 0, 16'h0000, 16'h0001);
        m_done("rr0");
        m_wait_start("rr1", 10);
        m_expect("rr1", 2'b10, 15, 16'h0000, 16'h8000);
        m_done("rr1");
        m_wait_start("rr2", 10);
        m_expect("rr2", 2'b10, 0, 16'h0000, 16'h0001);
        m_if.i_learn_req = 16'h0003;
        m_done("rr2");
        m_wait_start("rr3", 10);
        m_expect("rr3", 2'b10, 1, 16'h0000, 16'h0002);
        m_if.i_learn_req = '0;
        m_done("rr3");

        // Lookup burst cap against a held learn request on port 5
        m_if.i_lkp_req   = 16'hFFFF;
        m_if.i_learn_req = 16'h0020;
        for (int i = 0; i < 10; i++) begin
            m_wait_start($sformatf("burst%0d", i), 10);
            m_expect($sformatf("burst%0d", i), b_type[i], b_port[i],
                     (b_type[i] == 2'b01) ? 16'(32'd1 << b_port[i]) : 16'h0000,
                     (b_type[i] == 2'b10) ? 16'(32'd1 << b_port[i]) : 16'h0000);
            if (i == 9) begin
                m_if.i_lkp_req   = '0;
                m_if.i_learn_req = '0;
            end
            m_done($sformatf("burst%0d", i));
        end
        step();
        chk("burst_idle", 32'(m_if.o_busy), 0);

        // Reset while busy with a learn; pointer must restart at 0
        m_if.i_learn_req = 16'h0004;
        step();
        chk("rstmid_start", 32'(m_if.o_op_start), 1);
        m_expect("rstmid", 2'b10, 2, 16'h0000, 16'h0004);
        m_if.i_learn_req = 16'h0012;
        #2 rst_m = 1'b0;
        #1;
        chk("rstmid_async_start", 32'(m_if.o_op_start), 0);
        chk("rstmid_async_type", 32'(m_if.o_op_type), 0);
        chk("rstmid_async_port", 32'(m_if.o_op_port), 0);
        chk("rstmid_async_busy", 32'(m_if.o_busy), 0);
        chk("rstmid_async_gnt", 32'(m_if.o_learn_gnt), 0);
        #1 rst_m = 1'b1;
        step();
        chk("rstmid_regrant_start", 32'(m_if.o_op_start), 1);
        m_expect("rstmid_regrant", 2'b10, 1, 16'h0000, 16'h0002);
        m_if.i_learn_req = '0;
        m_done("rstmid_regrant");

        // Aging sweep on a 4-entry table, no other traffic
        rst_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_wait_start($sformatf("sweep%0d", k), 70);
            chk($sformatf("sweep%0d_type", k), 32'(a_if.o_op_type), 3);
            chk($sformatf("sweep%0d_addr", k), 32'(a_if.o_age_addr), k);
            chk($sformatf("sweep%0d_port", k), 32'(a_if.o_op_port), 0);
            chk($sformatf("sweep%0d_gnts", k), 32'({a_if.o_lkp_gnt, a_if.o_learn_gnt}), 0);
            a_done();
        end
        chk("sweep_addr_wrap", 32'(a_if.o_age_addr), 0);
        quiet = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (a_if.o_op_start === 1'b1) quiet++;
        end
        chk("sweep_inactive", quiet, 0);

        // Learn/age alternation once a sweep begins under a held learn request
        rst_a = 1'b0;
        a_if.i_learn_req = 16'h0001;
        step();
        rst_a = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            a_wait_start("alt_pre", 10);
            if (a_if.o_op_type === 2'b11) seen = 1'b1;
            else a_done();
            n++;
        end
        chk("alt_first_age", 32'(seen), 1);
        chk("alt_first_addr", 32'(a_if.o_age_addr), 0);
        a_done();
        exp_addr = 1;
        for (int i = 0; i < 8; i++) begin
            a_wait_start($sformatf("alt%0d", i), 10);
            chk($sformatf("alt%0d_type", i), 32'(a_if.o_op_type), 32'(alt_seq[i]));
            if (alt_seq[i] == 2'b11) begin
                chk($sformatf("alt%0d_addr", i), 32'(a_if.o_age_addr), exp_addr);
                exp_addr++;
            end
            a_done();
        end
        a_if.i_learn_req = '0;

        // Sweep overrun: slow datapath, short aging period
        ovr_base = ovr_cnt;
        rst_o = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (o_if.o_op_start !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            chk($sformatf("ovr%0d_start", k), 32'(o_if.o_op_start), 1);
            chk($sformatf("ovr%0d_type", k), 32'(o_if.o_op_type), 3);
            chk($sformatf("ovr%0d_addr", k), 32'(o_if.o_age_addr), k);
            repeat (9) step();
            o_if.i_op_done = 1'b1;
            step();
            o_if.i_op_done = 1'b0;
        end
        chk("ovr_pulse_seen", 32'(ovr_cnt != ovr_base), 1);
        chk("ovr_pulse_width", ovr_wide, 0);
        chk("ovr_addr_wrap", 32'(o_if.o_age_addr), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
